cdb_arbiter: RTL
================

# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the functional units of the out-of-order core. Each cycle it grants at most one requester, either a functional unit or the load unit. It then registers that requester's result value and destination tag onto the CDB. The CDB feeds the register file's `data_in_CDB`/`tag_in_CDB` inputs and the reservation stations. Requesters use a valid/ready handshake and must hold their payload until accepted.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..16.
- `DATA_W`, 32: result width.
- `TAG_W`, 8: tag width. Tag value 0 means "no tag".
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-low.
- `en` in 1: global enable. When low, no grants are made and the CDB output goes idle.
- `req_valid` in NUM_REQ: request per port.
- `req_data` in NUM_REQ*DATA_W: port i occupies bits [i*DATA_W +: DATA_W].
- `req_tag` in NUM_REQ*TAG_W: port i occupies bits [i*TAG_W +: TAG_W].
- `req_ready` out NUM_REQ: one-hot or zero. Transfer occurs when `req_valid[i] & req_ready[i]`.
- `cdb_valid` out 1: a broadcast is present this cycle.
- `data_out_CDB` out DATA_W: broadcast value.
- `tag_out_CDB` out TAG_W: broadcast tag. Equals 0 whenever `cdb_valid` is 0.
- `grant_id` out $clog2(NUM_REQ): index of the port that sourced the current broadcast. Debug only.

## Operation
- Round-robin pointer `rr_ptr` starts at 0.
- Each cycle with `en`=1, the winner is the first i with `req_valid[i]`=1, scanning from `rr_ptr` upward and wrapping from NUM_REQ-1 to 0.
- `req_ready[winner]`=1; all other bits are 0. Without CDB_SKID_EN this is a combinational function of `req_valid`, `rr_ptr` and `en`.
- On transfer, the output register loads `{1, req_data[winner], req_tag[winner]}` and `rr_ptr` becomes winner+1 mod NUM_REQ.
- With no valid request, or with `en`=0:
  - The output register loads idle: `cdb_valid`=0, data 0, tag 0.
  - `rr_ptr` holds.
  - `req_ready` is all 0.
- A request with tag 0 is accepted (`req_ready` asserted, pointer advances), but the broadcast is suppressed: `cdb_valid`=0, data 0, tag 0.
- Requesters must keep valid, data and tag stable until ready. Dropping valid before ready is legal; the port is simply not considered.
- Every broadcast lasts exactly one cycle. A tag is never broadcast twice for a single transfer.

## Timing
- Reset (`reset`=0 at a clock edge):
  - `cdb_valid`=0, `data_out_CDB`=0, `tag_out_CDB`=0, `grant_id`=0.
  - `rr_ptr`=0.
  - `req_ready`=0 while `reset` is low.
  - Any result already accepted but not yet broadcast is discarded.
- Latency: a transfer in cycle N appears on the CDB in cycle N+1. With CDB_SKID_EN the latency is N+2.
- Throughput: one broadcast per cycle while any request is pending.
- Fairness: a continuously valid port is granted within NUM_REQ cycles.
- If `en` falls in cycle N, the cycle N+1 CDB is idle. A broadcast registered at the cycle-N edge (from a cycle N-1 transfer) is still visible during cycle N.

## Configuration
- `CDB_SKID_EN` defined:
  - Each port gets a one-entry input buffer.
  - `req_ready[i]` = buffer i empty, driven from a register with no combinational path from `req_valid`.
  - Arbitration runs over buffer-valid bits instead of `req_valid`.
  - Buffers clear on reset. `en`=0 stalls arbitration but still lets empty buffers accept.
- Undefined: no buffers; `req_ready` is combinational as described in Operation.

## Structure
- `cdb_pkg` holds:
  - `TAG_W`, `DATA_W` and `TAG_NONE` = 8'd0.
  - `typedef struct packed {logic [DATA_W-1:0] data; logic [TAG_W-1:0] tag;} cdb_msg_t`, used for the output register and the skid buffers.
- Sub-module `cdb_rr_picker`: combinational. Inputs are the request mask and `rr_ptr`; outputs are `any` and `winner` index. It holds the wrap-around scan and can be unit-tested alone.

## Test plan
- Reset, then `req_valid`=4'b0000 for 5 cycles -> `cdb_valid`=0, `tag_out_CDB`=0 and `req_ready`=0 every cycle.
- Single request: port 2 with data 32'hDEAD_BEEF, tag 8'h15 in cycle 3 -> `req_ready`=4'b0100 in cycle 3; cycle 4 shows `cdb_valid`=1, data DEAD_BEEF, tag 15, `grant_id`=2; cycle 5 is idle.
- All four ports valid continuously (tags 1..4) -> broadcast tag order 1,2,3,4,1 on consecutive cycles with no gaps.
- Port 0 holds valid while port 3 pulses once -> port 3 is broadcast within 4 cycles; port 0 is never granted twice in a row while port 3 is waiting.
- Tag 0 request on port 1 -> `req_ready[1]`=1; the next cycle has `cdb_valid`=0 and tag 0; the pointer advances to 2.
- `reset` driven low in the cycle after a grant -> the next cycle's CDB is idle with tag 0. With CDB_SKID_EN, a full buffer is also emptied.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus (CDB) arbiter.
// The message struct is the payload held in the output register and the skid buffers.
package cdb_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 8;

    localparam logic [TAG_W-1:0] TAG_NONE = 8'd0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } cdb_msg_t;

    // The value the CDB carries when nothing is broadcast.
    function automatic cdb_msg_t cdb_idle();
        cdb_msg_t m;
        m.data = 32'd0;
        m.tag  = TAG_NONE;
        return m;
    endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational round-robin picker: returns the first set bit of req_mask_i,
// scanning upward from rr_ptr_i and wrapping from NUM_REQ-1 back to 0.
module cdb_rr_picker #(
    parameter int  NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_mask_i,
    input  logic [IW-1:0]      rr_ptr_i,
    output logic               any_o,
    output logic [IW-1:0]      winner_o
);

    logic [IW:0]   sum_s;
    logic [IW-1:0] idx_s;

    // Scan from the farthest offset down to offset 0 so the nearest request wins.
    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        sum_s    = '0;
        idx_s    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum_s    = {1'b0, rr_ptr_i} + (IW + 1)'(k);
            idx_s    = (sum_s >= (IW + 1)'(NUM_REQ)) ? IW'(sum_s - (IW + 1)'(NUM_REQ))
                                                     : IW'(sum_s);
            any_o    = any_o | req_mask_i[idx_s];
            winner_o = req_mask_i[idx_s] ? idx_s : winner_o;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants one requester per cycle and registers its result onto the CDB.
// Define CDB_SKID_EN to add a one-entry input buffer per port with registered req_ready.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DATA_W  = cdb_pkg::DATA_W,
    parameter int  TAG_W   = cdb_pkg::TAG_W,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       cdb_valid,
    output logic [DATA_W-1:0]          data_out_CDB,
    output logic [TAG_W-1:0]           tag_out_CDB,
    output logic [IW-1:0]              grant_id
);

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;
    logic               out_valid_q, out_valid_d;
    cdb_msg_t           out_msg_q, out_msg_d;

    logic [NUM_REQ-1:0] arb_mask_s;
    logic [NUM_REQ-1:0] ready_s;
    logic               any_s;
    logic [IW-1:0]      winner_s;
    cdb_msg_t           win_msg_s;

    cdb_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_mask_i (arb_mask_s),
        .rr_ptr_i   (rr_ptr_q),
        .any_o      (any_s),
        .winner_o   (winner_s)
    );

`ifdef CDB_SKID_EN
    logic [NUM_REQ-1:0] buf_valid_q, buf_valid_d;
    cdb_msg_t           buf_msg_q [NUM_REQ];
    cdb_msg_t           buf_msg_d [NUM_REQ];

    // Arbitrate over buffered entries; ready depends only on buffer occupancy.
    always_comb begin
        arb_mask_s = en ? buf_valid_q : '0;
        ready_s    = reset ? ~buf_valid_q : '0;
        win_msg_s  = buf_msg_q[winner_s];
    end

    // A full buffer is never ready, so a port cannot be pushed and popped together.
    always_comb begin
        buf_valid_d = buf_valid_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            buf_msg_d[i] = buf_msg_q[i];
            if (req_valid[i] && ready_s[i]) begin
                buf_valid_d[i]   = 1'b1;
                buf_msg_d[i].data = req_data[i*DATA_W +: DATA_W];
                buf_msg_d[i].tag  = req_tag[i*TAG_W +: TAG_W];
            end else if (any_s && (winner_s == IW'(i))) begin
                buf_valid_d[i] = 1'b0;
            end else begin
                buf_valid_d[i] = buf_valid_q[i];
            end
        end
    end

    // Skid buffer registers; reset discards anything accepted but not yet broadcast.
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_valid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_msg_q[i] <= cdb_idle();
            end
        end else begin
            buf_valid_q <= buf_valid_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_msg_q[i] <= buf_msg_d[i];
            end
        end
    end
`else
    // Direct arbitration over live requests; ready is a function of valid, pointer and en.
    always_comb begin
        arb_mask_s     = en ? req_valid : '0;
        ready_s        = (reset && any_s) ? (NUM_REQ'(1) << winner_s) : '0;
        win_msg_s.data = req_data[int'(winner_s)*DATA_W +: DATA_W];
        win_msg_s.tag  = req_tag[int'(winner_s)*TAG_W +: TAG_W];
    end
`endif

    // Pointer advance and output register load; tag-0 transfers are consumed silently.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        out_valid_d = 1'b0;
        out_msg_d   = cdb_idle();
        if (any_s) begin
            rr_ptr_d = (winner_s == IW'(NUM_REQ - 1)) ? '0 : winner_s + IW'(1);
            if (win_msg_s.tag != TAG_NONE) begin
                out_valid_d = 1'b1;
                out_msg_d   = win_msg_s;
                grant_id_d  = winner_s;
            end else begin
                out_valid_d = 1'b0;
                out_msg_d   = cdb_idle();
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State and CDB output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            out_valid_q <= 1'b0;
            out_msg_q   <= cdb_idle();
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            out_valid_q <= out_valid_d;
            out_msg_q   <= out_msg_d;
        end
    end

    assign req_ready    = ready_s;
    assign cdb_valid    = out_valid_q;
    assign data_out_CDB = out_msg_q.data;
    assign tag_out_CDB  = out_msg_q.tag;
    assign grant_id     = grant_id_q;

endmodule
